// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key event receiver.
package ps2_pkg;

    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned EVT_W      = 10;
    localparam logic [7:0]  PFX_EXT    = 8'hE0;
    localparam logic [7:0]  PFX_BRK    = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_E0   = 2'd1,
        ST_F0   = 2'd2,
        ST_E0F0 = 2'd3
    } dec_state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } key_event_t;

    // Frame bit 0 is start, bits 8:1 data, bit 9 odd parity, bit 10 stop.
    function automatic logic frame_ok(input logic [FRAME_BITS-1:0] f);
        return !f[0] && f[FRAME_BITS-1] && (^f[9:1]);
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line synchroniser, clock glitch filter, 11-bit deframer and frame timeout.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned TIMEOUT    = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_vld,
    output logic       parity_err,
    output logic       timeout_err
);

    localparam int unsigned FLT_W = $clog2(FILTER_LEN + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [3:0]       LAST_BIT = 4'(FRAME_BITS - 1);

    logic                  clk_s1, clk_s2, dat_s1, dat_s2;
    logic                  clk_filt, strobe;
    logic [FLT_W-1:0]      flt_cnt;
    logic [3:0]            bit_cnt;
    logic [9:0]            shreg;
    logic [TO_W-1:0]       to_cnt;
    logic [FRAME_BITS-1:0] frame;

    assign frame = {dat_s2, shreg};

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Level flips on the FILTER_LEN-th consecutive differing sample; strobe marks a falling flip.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_filt <= 1'b1;
            flt_cnt  <= '0;
            strobe   <= 1'b0;
        end else begin
            strobe <= 1'b0;
            if (clk_s2 != clk_filt) begin
                if (flt_cnt == FLT_LAST) begin
                    clk_filt <= clk_s2;
                    flt_cnt  <= '0;
                    strobe   <= clk_filt;
                end else begin
                    flt_cnt <= flt_cnt + 1'b1;
                end
            end else begin
                flt_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt     <= '0;
            to_cnt      <= '0;
            shreg       <= '0;
            rx_byte     <= '0;
            byte_vld    <= 1'b0;
            parity_err  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            byte_vld    <= 1'b0;
            parity_err  <= 1'b0;
            timeout_err <= 1'b0;
            if (strobe) begin
                to_cnt <= '0;
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt <= '0;
                    if (frame_ok(frame)) begin
                        rx_byte  <= frame[8:1];
                        byte_vld <= 1'b1;
                    end else begin
                        parity_err <= 1'b1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                    shreg   <= {dat_s2, shreg[9:1]};
                end
            end else if (bit_cnt != '0) begin
                if (to_cnt == TO_LAST) begin
                    bit_cnt     <= '0;
                    to_cnt      <= '0;
                    timeout_err <= 1'b1;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: scan-code prefix decoder feeding a fall-through event FIFO.
module ps2_key_event_rx
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned FILTER_LEN = 4,
    parameter int unsigned TIMEOUT    = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    input  logic             rdn,
    output logic [EVT_W-1:0] data,
    output logic             ready,
    output logic             overflow,
    output logic             parity_err,
    output logic             timeout_err
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0] rx_byte;
    logic       byte_vld;

    ps2_frame_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) u_frame (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .rx_byte     (rx_byte),
        .byte_vld    (byte_vld),
        .parity_err  (parity_err),
        .timeout_err (timeout_err)
    );

    dec_state_t state, state_nxt;
    logic       push;
    key_event_t push_evt;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        push          = 1'b0;
        push_evt.ext  = (state == ST_E0) || (state == ST_E0F0);
        push_evt.brk  = (state == ST_F0) || (state == ST_E0F0);
        push_evt.code = rx_byte;
        if (byte_vld) begin
            if (rx_byte == PFX_EXT) begin
                state_nxt = ST_E0;
            end else if (rx_byte == PFX_BRK) begin
                case (state)
                    ST_IDLE: state_nxt = ST_F0;
                    ST_E0:   state_nxt = ST_E0F0;
                    default: state_nxt = state;
                endcase
            end else begin
                push      = 1'b1;
                state_nxt = ST_IDLE;
            end
        end
    end

    key_event_t mem [DEPTH];
    logic [AW:0] wptr, rptr;
    logic        empty, full, pop, wr_en;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign ready = !empty;
    assign pop   = !rdn && !empty;
    // A pop frees the head slot in the same cycle, so a full FIFO can still take the push.
    assign wr_en = push && (!full || pop);
    assign data  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (pop)   rptr <= rptr + 1'b1;
            if (push && full && !pop) overflow <= 1'b1;
            else if (pop)             overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[AW-1:0]] <= push_evt;
    end

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Directed bench for ps2_key_event_rx: vector table plus hand-written corner sequences.
module tb_ps2_key_event_rx;

    localparam int unsigned DEPTH      = 8;
    localparam int unsigned FILTER_LEN = 4;
    localparam int unsigned TIMEOUT    = 200;
    localparam int unsigned HALF       = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rdn = 1'b1;
    logic [9:0] data;
    logic       ready, overflow, parity_err, timeout_err;

    int checks = 0;
    int errors = 0;
    int perr_cnt = 0;
    int terr_cnt = 0;
    int wide_cnt = 0;
    logic perr_q = 1'b0;
    logic terr_q = 1'b0;

    always #5 clk = ~clk;

    ps2_key_event_rx #(
        .DEPTH      (DEPTH),
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .rdn         (rdn),
        .data        (data),
        .ready       (ready),
        .overflow    (overflow),
        .parity_err  (parity_err),
        .timeout_err (timeout_err)
    );

    always @(negedge clk) begin
        if (parity_err === 1'b1) perr_cnt++;
        if (timeout_err === 1'b1) terr_cnt++;
        if ((parity_err === 1'b1 && perr_q) || (timeout_err === 1'b1 && terr_q)) wide_cnt++;
        perr_q = (parity_err === 1'b1);
        terr_q = (timeout_err === 1'b1);
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic flip);
        return {1'b1, (~^b) ^ flip, b, 1'b0};
    endfunction

    task automatic send_bit(input logic b);
        ps2_data = b;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    // r7/r8: ready sampled 7 and 8 clk edges after the bit-10 falling edge is driven
    // (2 sync + FILTER_LEN filter + 2 decode/push).
    task automatic send_frame(input logic [7:0] b, input logic flip, input logic pop_at_push,
                              output logic r7, output logic r8);
        logic [10:0] f;
        f = mk_frame(b, flip);
        for (int i = 0; i < 10; i++) send_bit(f[i]);
        ps2_data = f[10];
        tick(HALF);
        ps2_clk = 1'b0;
        tick(7);
        r7 = ready;
        if (pop_at_push) rdn = 1'b0;
        tick(1);
        rdn = 1'b1;
        r8 = ready;
        tick(HALF - 8);
        ps2_clk = 1'b1;
        tick(HALF);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic a, c;
        send_frame(b, 1'b0, 1'b0, a, c);
    endtask

    task automatic pop_one;
        rdn = 1'b0;
        tick(1);
        rdn = 1'b1;
    endtask

    task automatic glitch(input int unsigned n);
        ps2_clk = 1'b0;
        tick(n);
        ps2_clk = 1'b1;
        tick(12);
    endtask

    typedef struct {
        logic [23:0] bytes;   // byte j at [8*j +: 8]
        int unsigned n;
        logic [9:0]  exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic r7, r8;
        logic [10:0] f;
        int p0, t0;
        logic [7:0] drain [8];

        vecs[0] = '{24'h00001C, 1, 10'h01C};
        vecs[1] = '{24'h75F0E0, 3, 10'h375};
        vecs[2] = '{24'h001CF0, 2, 10'h11C};
        vecs[3] = '{24'h0075E0, 2, 10'h275};
        vecs[4] = '{24'h1CE0E0, 3, 10'h21C};
        vecs[5] = '{24'h1CF0F0, 3, 10'h11C};
        vecs[6] = '{24'h1CE0F0, 3, 10'h21C};
        vecs[7] = '{24'h000083, 1, 10'h083};

        tick(5);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_parity_err", 32'(parity_err), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);
        rst = 1'b0;
        tick(HALF);

        send_frame(8'h1C, 1'b0, 1'b0, r7, r8);
        chk("lat_ready_early", 32'(r7), 0);
        chk("lat_ready_2cyc", 32'(r8), 1);
        chk("lat_data", 32'(data), 32'h01C);
        pop_one();
        chk("lat_pop_empty", 32'(ready), 0);

        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < int'(vecs[i].n); j++) begin
                send_byte(vecs[i].bytes[8*j +: 8]);
                if (j < int'(vecs[i].n) - 1) chk("vec_prefix_quiet", 32'(ready), 0);
            end
            chk("vec_ready", 32'(ready), 1);
            chk("vec_data", 32'(data), 32'(vecs[i].exp));
            pop_one();
            chk("vec_empty", 32'(ready), 0);
        end

        send_byte(8'hE0);
        p0 = perr_cnt;
        send_frame(8'h1C, 1'b1, 1'b0, r7, r8);
        chk("par_pulse", 32'(perr_cnt - p0), 1);
        chk("par_no_event", 32'(ready), 0);
        send_byte(8'h1C);
        chk("par_state_kept", 32'(data), 32'h21C);
        pop_one();

        send_byte(8'hE0);
        f = mk_frame(8'h44, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(f[i]);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(HALF);
        send_byte(8'h1C);
        chk("rst_mid_frame", 32'(data), 32'h01C);
        pop_one();
        chk("rst_mid_empty", 32'(ready), 0);

        t0 = terr_cnt;
        p0 = perr_cnt;
        f = mk_frame(8'h55, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(f[i]);
        for (int k = 0; k < int'(TIMEOUT) + 50 && terr_cnt == t0; k++) tick(1);
        tick(5);
        chk("to_pulse", 32'(terr_cnt - t0), 1);
        send_byte(8'h29);
        chk("to_recover", 32'(data), 32'h029);
        chk("to_no_parity", 32'(perr_cnt - p0), 0);
        pop_one();

        p0 = perr_cnt;
        t0 = terr_cnt;
        glitch(1);
        glitch(FILTER_LEN - 1);
        send_byte(8'h5A);
        chk("gl_idle_data", 32'(data), 32'h05A);
        pop_one();
        f = mk_frame(8'h66, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(f[i]);
        glitch(1);
        glitch(FILTER_LEN - 1);
        for (int i = 4; i < 11; i++) send_bit(f[i]);
        tick(HALF);
        chk("gl_mid_data", 32'(data), 32'h066);
        chk("gl_no_errs", 32'((perr_cnt - p0) + (terr_cnt - t0)), 0);
        pop_one();

        for (int k = 1; k <= 8; k++) send_byte(8'(k));
        chk("ov_not_yet", 32'(overflow), 0);
        chk("ov_head8", 32'(data), 32'h001);
        send_byte(8'h09);
        chk("ov_set", 32'(overflow), 1);
        chk("ov_head_kept", 32'(data), 32'h001);
        pop_one();
        chk("ov_clear_pop", 32'(overflow), 0);
        chk("ov_next", 32'(data), 32'h002);
        send_byte(8'h0A);
        chk("ov_refill", 32'(overflow), 0);
        send_frame(8'h0B, 1'b0, 1'b1, r7, r8);
        chk("ov_push_pop_full", 32'(overflow), 0);
        drain = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A, 8'h0B};
        for (int k = 0; k < 8; k++) begin
            chk("ov_drain", 32'(data), 32'(drain[k]));
            pop_one();
        end
        chk("ov_drained", 32'(ready), 0);

        chk("pulse_width", 32'(wide_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_key_event_rx.md
PS2_KEY_EVENT_RX -- requirements
Module: ps2_key_event_rx

Interface
REQ-001 SHALL have parameter DEPTH, default 8, event FIFO entries (power of 2, >=2; all DEPTH usable).
REQ-002 SHALL have parameter FILTER_LEN, default 4, consecutive equal clk samples needed to accept a ps2_clk level change.
REQ-003 SHALL have parameter TIMEOUT, default 100000, clk cycles without a sampled bit before a partial frame is aborted.
REQ-004 SHALL have port clk  in  1  system clock; the only clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port ps2_clk  in  1  asynchronous PS/2 clock line.
REQ-007 SHALL have port ps2_data  in  1  asynchronous PS/2 data line.
REQ-008 SHALL have port rdn  in  1  pop request, active-low; sampled each clk.
REQ-009 SHALL have port data  out  10  head event {ext, brk, code[7:0]}, valid while ready=1.
REQ-010 SHALL have port ready  out  1  FIFO not empty.
REQ-011 SHALL have port overflow  out  1  sticky: event dropped because FIFO full.
REQ-012 SHALL have port parity_err  out  1  one-cycle pulse: frame rejected (start/stop/parity).
REQ-013 SHALL have port timeout_err  out  1  one-cycle pulse: partial frame aborted.

Function
REQ-014 SHALL synchronise ps2_clk and ps2_data through two flops each before any use.
REQ-015 SHALL change the filtered ps2_clk level only after FILTER_LEN consecutive synchronised samples differ from it; sample strobe = filtered 1->0 transition, one cycle wide.
REQ-016 SHALL deframe 11 bits per frame: start(0), data[7:0] LSB first, odd parity, stop(1); bit counter 0..10.
REQ-017 SHALL, on the strobe of bit 10, accept the byte only if start=0, stop=1 and XOR(data,parity)=1; otherwise pulse parity_err and discard the byte; counter returns to 0 either way.
REQ-018 SHALL, when counter!=0 and TIMEOUT cycles elapse with no strobe, reset counter to 0 and pulse timeout_err; no timeout when counter=0.
REQ-019 SHALL run a decoder FSM with states IDLE, E0, F0, E0F0 on each accepted byte.
REQ-020 SHALL transition: byte 0xE0 in any state -> E0; byte 0xF0: IDLE->F0, E0->E0F0, F0/E0F0 unchanged; any other byte -> push event and -> IDLE.
REQ-021 SHALL form the pushed event as ext=(state in E0,E0F0), brk=(state in F0,E0F0), code=byte; prefix bytes are never pushed.
REQ-022 SHALL leave decoder state unchanged on rejected or aborted frames.
REQ-023 SHALL raise ready exactly 2 clk cycles after the cycle in which the bit-10 strobe is high, for a byte that pushes into a non-full FIFO.
REQ-024 SHALL present data combinationally from the FIFO head (first-word fall-through).
REQ-025 SHALL pop on a cycle where rdn=0 and ready=1; rdn=0 with ready=0 is ignored.
REQ-026 SHALL, on push when full with no simultaneous pop, drop the event and set overflow; existing entries untouched.
REQ-027 SHALL, on simultaneous push and pop when full, accept both; overflow not set.
REQ-028 SHALL clear overflow on any pop; set takes priority if both occur in the same cycle.
REQ-029 SHALL wrap read/write pointers modulo DEPTH, using one extra pointer bit for full/empty distinction.

Reset
REQ-030 SHALL, while rst=1 at a clk edge, clear bit counter, timeout counter, FSM (IDLE), FIFO pointers, overflow; ready=0, parity_err=0, timeout_err=0 next cycle.
REQ-031 SHALL set filtered ps2_clk and synchroniser flops to 1 (idle bus) on reset.
REQ-032 SHALL discard any partial frame when rst asserts mid-frame; FIFO contents not required to clear.

Structure
REQ-033 SHALL place frame length (11), prefix constants (0xE0, 0xF0), FSM state encoding and event width (10) in shared package ps2_pkg.
REQ-034 SHALL implement sync, filter, deframer and timeout in sub-module ps2_frame_rx (outputs byte[7:0], byte_vld pulse, parity_err, timeout_err); decoder and FIFO in the top.

Verification
REQ-035 SHALL test: frame 0x1C (parity 0) -> ready after 2 cycles, data=0x01C; one pop -> ready=0.
REQ-036 SHALL test: bytes E0,F0,75 -> single event data=0x375 (ext=1,brk=1); bytes F0,1C -> 0x11C.
REQ-037 SHALL test: frame 0x1C with parity 1 -> parity_err pulse, no event, FSM state kept (preceding E0 still applies to next 0x1C -> 0x21C).
REQ-038 SHALL test: DEPTH=8, push 9 codes 0x01..0x09 without popping -> overflow=1, FIFO holds 0x01..0x08; pop -> overflow=0, data=0x002.
REQ-039 SHALL test: 4 bits then silence TIMEOUT cycles -> timeout_err pulse; next full frame 0x29 decodes to 0x029.
REQ-040 SHALL test: 1-cycle and (FILTER_LEN-1)-cycle low glitches on ps2_clk -> no strobe, bit counter unchanged.
